// File: rtl/sd_card_cmd_responder_pkg.sv
// Shared types and frame constants for the SD card-side CMD line responder.
package SdCardPkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RECV_CMD,
        ST_WAIT_RSP,
        ST_NCR,
        ST_SEND_RSP
    } state_t;

    // CRC7 generator x^7 + x^3 + 1 (feedback taps below the x^7 term)
    localparam logic [6:0] CRC7_POLY = 7'h09;

    localparam int unsigned FRAME_BITS    = 48;
    localparam int unsigned CRC_SPAN_BITS = 40;
    localparam int unsigned CRC_BITS      = 7;

    // Bit positions within a 48-bit frame (bit 47 = start bit)
    localparam int unsigned TX_BIT_POS  = 46;
    localparam int unsigned IDX_LSB     = 40;
    localparam int unsigned ARG_LSB     = 8;
    localparam int unsigned CRC_LSB     = 1;
    localparam int unsigned END_BIT_POS = 0;

    // CRC field sent for R3-style responses
    localparam logic [6:0] CRC_NONE = 7'h7F;

    function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
        logic fb;
        fb = din ^ crc[6];
        return {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
    endfunction

endpackage

// File: rtl/sd_card_cmd_responder_crc7.sv
// Serial CRC7 accumulator; Clear together with Enable restarts from zero
// and absorbs DataIn in the same cycle.
module sd_crc7
    import SdCardPkg::*;
(
    input  logic       Clk,
    input  logic       Clear,
    input  logic       Enable,
    input  logic       DataIn,
    output logic [6:0] Crc
);

    logic [6:0] crc_q;
    logic [6:0] base;

    assign base = Clear ? '0 : crc_q;
    assign Crc  = crc_q;

    // Accumulate one bit per enabled cycle, or clear
    always_ff @(posedge Clk) begin
        if (Enable) begin
            crc_q <= crc7_step(base, DataIn);
        end else if (Clear) begin
            crc_q <= '0;
        end
    end

endmodule

// File: rtl/sd_card_cmd_responder.sv
// Card-side SD CMD line endpoint: receives 48-bit host commands, checks
// framing and CRC7, hands index/argument to the card model and serialises
// the 48-bit response after the Ncr gap.
module sd_card_cmd_responder
    import SdCardPkg::*;
#(
    parameter int unsigned NCR_CYCLES  = 2,
    parameter int unsigned RSP_TIMEOUT = 64
) (
    input  logic        Clk,
    input  logic        ResetSync,
    input  logic        CmdIn,
    output logic        CmdOut,
    output logic        CmdOutEn,
    output logic        CmdValid,
    output logic [5:0]  CmdIndex,
    output logic [31:0] CmdArg,
    output logic        CrcError,
    output logic        FrameError,
    input  logic        RspValid,
    output logic        RspReady,
    input  logic [5:0]  RspIndex,
    input  logic [31:0] RspArg,
    input  logic        RspNoCrc,
    output logic        RspDone
);

    localparam logic [6:0] LAST_BIT  = 7'(FRAME_BITS - 1);
    localparam logic [6:0] CRC_END   = 7'(CRC_SPAN_BITS);
    localparam logic [6:0] FRAME_END = 7'(FRAME_BITS);
    localparam logic [6:0] NCR_CNT   = 7'(NCR_CYCLES);
    localparam logic [6:0] TMO_CNT   = 7'(RSP_TIMEOUT);

    state_t      state_q, state_n;
    logic [6:0]  cnt_q, cnt_n;
    logic [47:0] shreg_q, shreg_n;
    logic        cmd_out_q, cmd_out_n;
    logic        cmd_out_en_q, cmd_out_en_n;
    logic        cmd_valid_q, cmd_valid_n;
    logic        crc_err_q, crc_err_n;
    logic        frm_err_q, frm_err_n;
    logic        rsp_done_q, rsp_done_n;
    logic        rsp_ready_q, rsp_ready_n;
    logic [5:0]  idx_q, idx_n;
    logic [31:0] arg_q, arg_n;
    logic        no_crc_q, no_crc_n;

    logic        crc_clear, crc_en, crc_din;
    logic [6:0]  crc;
    logic [47:0] rx_frame;
    logic [7:0]  tail;

    sd_crc7 u_crc7 (
        .Clk    (Clk),
        .Clear  (crc_clear | ResetSync),
        .Enable (crc_en & ~ResetSync),
        .DataIn (crc_din),
        .Crc    (crc)
    );

    assign CmdOut     = cmd_out_q;
    assign CmdOutEn   = cmd_out_en_q;
    assign CmdValid   = cmd_valid_q;
    assign CmdIndex   = idx_q;
    assign CmdArg     = arg_q;
    assign CrcError   = crc_err_q;
    assign FrameError = frm_err_q;
    assign RspReady   = rsp_ready_q;
    assign RspDone    = rsp_done_q;

    // Next-state, shift register, counter and output decode
    always_comb begin
        state_n      = state_q;
        cnt_n        = cnt_q;
        shreg_n      = shreg_q;
        cmd_out_n    = cmd_out_q;
        cmd_out_en_n = cmd_out_en_q;
        cmd_valid_n  = 1'b0;
        crc_err_n    = 1'b0;
        frm_err_n    = 1'b0;
        rsp_done_n   = 1'b0;
        rsp_ready_n  = 1'b0;
        idx_n        = idx_q;
        arg_n        = arg_q;
        no_crc_n     = no_crc_q;
        crc_clear    = 1'b0;
        crc_en       = 1'b0;
        crc_din      = 1'b0;
        rx_frame     = {shreg_q[46:0], CmdIn};
        tail         = {(no_crc_q ? CRC_NONE : crc), 1'b1};

        unique case (state_q)
            ST_IDLE: begin
                if (!CmdIn) begin
                    crc_clear = 1'b1;
                    crc_en    = 1'b1;
                    crc_din   = CmdIn;
                    shreg_n   = {shreg_q[46:0], CmdIn};
                    cnt_n     = 7'd1;
                    state_n   = ST_RECV_CMD;
                end
            end

            ST_RECV_CMD: begin
                shreg_n = {shreg_q[46:0], CmdIn};
                if (cnt_q < CRC_END) begin
                    crc_en  = 1'b1;
                    crc_din = CmdIn;
                end
                if (cnt_q == LAST_BIT) begin
                    if (!rx_frame[TX_BIT_POS] || !rx_frame[END_BIT_POS]) begin
                        frm_err_n = 1'b1;
                        cnt_n     = '0;
                        state_n   = ST_IDLE;
                    end else if (rx_frame[CRC_LSB +: CRC_BITS] != crc) begin
                        crc_err_n = 1'b1;
                        cnt_n     = '0;
                        state_n   = ST_IDLE;
                    end else begin
                        idx_n       = rx_frame[IDX_LSB +: 6];
                        arg_n       = rx_frame[ARG_LSB +: 32];
                        cmd_valid_n = 1'b1;
                        rsp_ready_n = 1'b1;
                        cnt_n       = 7'd1;
                        state_n     = ST_WAIT_RSP;
                    end
                end else begin
                    cnt_n = cnt_q + 7'd1;
                end
            end

            // The counter keeps counting released cycles since the end bit
            // through WaitRsp and Ncr, so the Ncr gap includes the wait time.
            ST_WAIT_RSP: begin
                if (RspValid) begin
                    shreg_n  = {2'b00, RspIndex, RspArg, CRC_NONE, 1'b1};
                    no_crc_n = RspNoCrc;
                    cnt_n    = cnt_q + 7'd1;
                    state_n  = ST_NCR;
                end else if (cnt_q >= TMO_CNT) begin
                    cnt_n   = '0;
                    state_n = ST_IDLE;
                end else begin
                    rsp_ready_n = 1'b1;
                    cnt_n       = cnt_q + 7'd1;
                end
            end

            ST_NCR: begin
                if (cnt_q >= NCR_CNT) begin
                    cmd_out_n    = shreg_q[47];
                    cmd_out_en_n = 1'b1;
                    crc_clear    = 1'b1;
                    crc_en       = 1'b1;
                    crc_din      = shreg_q[47];
                    shreg_n      = {shreg_q[46:0], 1'b0};
                    cnt_n        = 7'd1;
                    state_n      = ST_SEND_RSP;
                end else begin
                    cnt_n = cnt_q + 7'd1;
                end
            end

            ST_SEND_RSP: begin
                if (cnt_q == FRAME_END) begin
                    cmd_out_n    = 1'b1;
                    cmd_out_en_n = 1'b0;
                    rsp_done_n   = 1'b1;
                    cnt_n        = '0;
                    state_n      = ST_IDLE;
                end else if (cnt_q == CRC_END) begin
                    cmd_out_n = tail[7];
                    shreg_n   = {tail[6:0], 41'd0};
                    cnt_n     = cnt_q + 7'd1;
                end else begin
                    cmd_out_n = shreg_q[47];
                    shreg_n   = {shreg_q[46:0], 1'b0};
                    if (cnt_q < CRC_END) begin
                        crc_en  = 1'b1;
                        crc_din = shreg_q[47];
                    end
                    cnt_n = cnt_q + 7'd1;
                end
            end

            default: begin
                cnt_n   = '0;
                state_n = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs with synchronous reset
    always_ff @(posedge Clk) begin
        if (ResetSync) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            shreg_q      <= '0;
            cmd_out_q    <= 1'b1;
            cmd_out_en_q <= 1'b0;
            cmd_valid_q  <= 1'b0;
            crc_err_q    <= 1'b0;
            frm_err_q    <= 1'b0;
            rsp_done_q   <= 1'b0;
            rsp_ready_q  <= 1'b0;
            idx_q        <= '0;
            arg_q        <= '0;
            no_crc_q     <= 1'b0;
        end else begin
            state_q      <= state_n;
            cnt_q        <= cnt_n;
            shreg_q      <= shreg_n;
            cmd_out_q    <= cmd_out_n;
            cmd_out_en_q <= cmd_out_en_n;
            cmd_valid_q  <= cmd_valid_n;
            crc_err_q    <= crc_err_n;
            frm_err_q    <= frm_err_n;
            rsp_done_q   <= rsp_done_n;
            rsp_ready_q  <= rsp_ready_n;
            idx_q        <= idx_n;
            arg_q        <= arg_n;
            no_crc_q     <= no_crc_n;
        end
    end

endmodule

// File: tb/tb_sd_card_cmd_responder.sv
// Scoreboard bench for sd_card_cmd_responder: stimulus queues expected
// events, a negedge monitor pops and compares as the DUT produces them.
module tb_sd_card_cmd_responder;

    localparam int NCR = 2;
    localparam int TMO = 64;

    logic        Clk = 1'b0;
    logic        ResetSync = 1'b1;
    logic        CmdIn = 1'b1;
    logic        CmdOut, CmdOutEn, CmdValid, CrcError, FrameError, RspReady, RspDone;
    logic [5:0]  CmdIndex;
    logic [31:0] CmdArg;
    logic        RspValid = 1'b0;
    logic [5:0]  RspIndex = '0;
    logic [31:0] RspArg = '0;
    logic        RspNoCrc = 1'b0;

    sd_card_cmd_responder #(
        .NCR_CYCLES  (NCR),
        .RSP_TIMEOUT (TMO)
    ) dut (
        .Clk        (Clk),
        .ResetSync  (ResetSync),
        .CmdIn      (CmdIn),
        .CmdOut     (CmdOut),
        .CmdOutEn   (CmdOutEn),
        .CmdValid   (CmdValid),
        .CmdIndex   (CmdIndex),
        .CmdArg     (CmdArg),
        .CrcError   (CrcError),
        .FrameError (FrameError),
        .RspValid   (RspValid),
        .RspReady   (RspReady),
        .RspIndex   (RspIndex),
        .RspArg     (RspArg),
        .RspNoCrc   (RspNoCrc),
        .RspDone    (RspDone)
    );

    always #5 Clk = ~Clk;

    typedef enum int {EV_CMD, EV_CRCERR, EV_FRMERR, EV_RSP, EV_DONE, EV_ABORT} ev_kind_t;
    typedef struct {
        ev_kind_t    kind;
        logic [47:0] data;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;
    int  valid_cyc = 0;
    int  drive_cycles = 0;
    int  nbits = 0;
    int  lat = 0;
    logic [47:0] rsp_bits = '0;

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    function automatic void expect_ev(ev_kind_t k, logic [47:0] d);
        ev_t e;
        e.kind = k;
        e.data = d;
        exp_q.push_back(e);
    endfunction

    function automatic void pop_check(string name, ev_kind_t k, logic [47:0] d, bit cmp_data);
        ev_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: unexpected event kind %0d with empty queue", name, k);
            return;
        end
        e = exp_q.pop_front();
        check({name, "_kind"}, 64'(e.kind), 64'(k));
        if (cmp_data) check({name, "_data"}, 64'(d), 64'(e.data));
    endfunction

    // Monitor: sample away from the active edge
    always @(negedge Clk) begin
        cyc++;
        if (CmdValid) begin
            pop_check("cmd", EV_CMD, {10'd0, CmdIndex, CmdArg}, 1'b1);
            valid_cyc = cyc;
        end
        if (CrcError)   pop_check("crcerr", EV_CRCERR, '0, 1'b0);
        if (FrameError) pop_check("frmerr", EV_FRMERR, '0, 1'b0);
        if (RspDone)    pop_check("done", EV_DONE, '0, 1'b0);
        if (CmdOutEn) begin
            if (nbits == 0) lat = cyc - valid_cyc;
            rsp_bits = {rsp_bits[46:0], CmdOut};
            nbits++;
            drive_cycles++;
            if (nbits == 48) begin
                pop_check("rsp", EV_RSP, rsp_bits, 1'b1);
                check("ncr_gap", 64'(lat), 64'(NCR));
                nbits = 0;
            end
        end else if (nbits != 0) begin
            pop_check("abort", EV_ABORT, 48'(nbits), 1'b1);
            nbits = 0;
        end
    end

    // Drive a 48-bit frame MSB first; caller is at a negedge
    task automatic send_cmd(input logic [47:0] f);
        CmdIn = f[47];
        for (int i = 46; i >= 0; i--) begin
            @(negedge Clk);
            CmdIn = f[i];
        end
        @(negedge Clk);
        CmdIn = 1'b1;
    endtask

    task automatic respond(input logic [5:0] idx, input logic [31:0] arg, input logic nocrc);
        int n;
        RspIndex = idx;
        RspArg   = arg;
        RspNoCrc = nocrc;
        RspValid = 1'b1;
        n = 0;
        while (!RspReady && n < 100) begin
            @(negedge Clk);
            n++;
        end
        check("rsp_ready_seen", 64'(RspReady), 64'd1);
        @(posedge Clk);
        #1 RspValid = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        do begin
            @(negedge Clk);
            n++;
        end while (!RspDone && n < 200);
        check("rsp_done_seen", 64'(RspDone), 64'd1);
    endtask

    task automatic wait_timeout();
        int n;
        int d0;
        n  = 0;
        d0 = drive_cycles;
        while (RspReady && n < 200) begin
            n++;
            @(negedge Clk);
        end
        check("timeout_len", 64'(n), 64'(TMO));
        check("timeout_no_drive", 64'(drive_cycles), 64'(d0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge Clk);
        check("rst_cmdouten", 64'(CmdOutEn), 64'd0);
        check("rst_cmdout", 64'(CmdOut), 64'd1);
        check("rst_index", 64'(CmdIndex), 64'd0);
        check("rst_arg", 64'(CmdArg), 64'd0);
        check("rst_ready", 64'(RspReady), 64'd0);
        check("rst_pulses", 64'({CmdValid, CrcError, FrameError, RspDone}), 64'd0);
        ResetSync = 1'b0;
        @(negedge Clk);

        // CMD0, no response offered: wait out the timeout
        expect_ev(EV_CMD, 48'd0);
        send_cmd(48'h40_00000000_95);
        wait_timeout();

        // CMD8 with R7-style reply
        expect_ev(EV_CMD, {10'd0, 6'd8, 32'h0000_01AA});
        expect_ev(EV_RSP, 48'h08_000001AA_13);
        expect_ev(EV_DONE, '0);
        send_cmd(48'h48_000001AA_87);
        respond(6'd8, 32'h0000_01AA, 1'b0);
        wait_done();

        // Back-to-back after RspDone: CMD8 with bad CRC field 7'h44
        expect_ev(EV_CRCERR, '0);
        send_cmd({8'h48, 32'h0000_01AA, 7'h44, 1'b1});
        check("crcerr_hold_index", 64'(CmdIndex), 64'd8);
        check("crcerr_hold_arg", 64'(CmdArg), 64'h1AA);
        check("crcerr_no_ready", 64'(RspReady), 64'd0);

        // Framing errors: end bit 0, then transmission bit 0
        expect_ev(EV_FRMERR, '0);
        send_cmd(48'h40_00000000_94);
        expect_ev(EV_FRMERR, '0);
        send_cmd(48'h00_00000000_01);
        check("frmerr_no_ready", 64'(RspReady), 64'd0);

        // R3-style response with fixed CRC field
        expect_ev(EV_CMD, 48'd0);
        expect_ev(EV_RSP, 48'h3F_80FF8000_FF);
        expect_ev(EV_DONE, '0);
        send_cmd(48'h40_00000000_95);
        respond(6'h3F, 32'h80FF_8000, 1'b1);
        wait_done();

        // Reset while response bit 20 is on the line
        expect_ev(EV_CMD, {10'd0, 6'd8, 32'h0000_01AA});
        expect_ev(EV_ABORT, 48'd21);
        send_cmd(48'h48_000001AA_87);
        respond(6'd8, 32'h0000_01AA, 1'b0);
        begin
            int n;
            n = 0;
            do begin
                @(negedge Clk);
                n++;
            end while (!CmdOutEn && n < 50);
            check("rsp_started", 64'(CmdOutEn), 64'd1);
        end
        repeat (20) @(negedge Clk);
        ResetSync = 1'b1;
        @(posedge Clk);
        #1;
        check("midrst_cmdouten", 64'(CmdOutEn), 64'd0);
        check("midrst_cmdout", 64'(CmdOut), 64'd1);
        check("midrst_index", 64'(CmdIndex), 64'd0);
        @(negedge Clk);
        ResetSync = 1'b0;

        // Normal decode after reset
        expect_ev(EV_CMD, 48'd0);
        send_cmd(48'h40_00000000_95);
        wait_timeout();

        repeat (5) @(negedge Clk);
        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
